// File: rtl/programmable_sequence_generator.sv
// Serialises a SEQ_W-bit pattern MSB first, repeating it repeat_cnt+1 times
// with an optional idle gap between copies. All outputs are registered.
module programmable_sequence_generator #(
  parameter int SEQ_W = 5,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [SEQ_W-1:0] init,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(SEQ_W);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(SEQ_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [SEQ_W-1:0] r_pat;
  logic [IDX_W-1:0] r_bit_idx;
  logic [CNT_W-1:0] r_rep_left;
  logic [GAP_W-1:0] r_gap_left;
  logic [GAP_W-1:0] r_gap_len;
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_busy;
  logic             r_done;

  logic [IDX_W-1:0] w_idx_dn;

  assign w_idx_dn = r_bit_idx - IDX_ONE;

  // r_bit_idx always names the bit currently presented on dout, so each edge
  // loads the bit for the following cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_pat        <= {SEQ_W{1'b0}};
      r_bit_idx    <= IDX_ZERO;
      r_rep_left   <= CNT_ZERO;
      r_gap_left   <= GAP_ZERO;
      r_gap_len    <= GAP_ZERO;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_state      <= ST_SEND;
            r_pat        <= init;
            r_rep_left   <= repeat_cnt;
            r_gap_len    <= gap_len;
            r_gap_left   <= GAP_ZERO;
            r_bit_idx    <= IDX_MAX;
            r_dout       <= init[SEQ_W-1];
            r_dout_valid <= 1'b1;
            r_busy       <= 1'b1;
          end else begin
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        ST_SEND: begin
          if (abort) begin
            r_state      <= ST_IDLE;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
          end else if (r_bit_idx != IDX_ZERO) begin
            r_bit_idx <= w_idx_dn;
            r_dout    <= r_pat[w_idx_dn];
          end else if (r_rep_left == CNT_ZERO) begin
            r_state      <= ST_IDLE;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end else begin
            r_rep_left <= r_rep_left - CNT_ONE;
            r_bit_idx  <= IDX_MAX;
            if (r_gap_len != GAP_ZERO) begin
              r_state      <= ST_GAP;
              r_gap_left   <= r_gap_len - GAP_ONE;
              r_dout       <= 1'b0;
              r_dout_valid <= 1'b0;
            end else begin
              r_dout <= r_pat[SEQ_W-1];
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            r_state      <= ST_IDLE;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
          end else if (r_gap_left == GAP_ZERO) begin
            r_state      <= ST_SEND;
            r_dout       <= r_pat[r_bit_idx];
            r_dout_valid <= 1'b1;
          end else begin
            r_gap_left <= r_gap_left - GAP_ONE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dout       <= 1'b0;
          r_dout_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_programmable_sequence_generator.sv
// Directed bench for programmable_sequence_generator with a looped-back
// behavioural detector for the pattern 5'b10110.
module tb_programmable_sequence_generator;

  localparam logic [4:0] DET_PAT = 5'b10110;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [4:0] init;
  logic [3:0] repeat_cnt;
  logic [2:0] gap_len;
  logic       abort;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  logic [4:0] det_hist;
  logic       det_seen;

  programmable_sequence_generator #(
    .SEQ_W(5), .CNT_W(4), .GAP_W(3)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .init(init),
    .repeat_cnt(repeat_cnt), .gap_len(gap_len), .abort(abort),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector model fed from dout: seen is registered, one cycle after a match.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      det_hist <= 5'b00000;
      det_seen <= 1'b0;
    end else begin
      det_seen <= 1'b0;
      if (dout_valid) begin
        det_hist <= {det_hist[3:0], dout};
        det_seen <= ({det_hist[3:0], dout} == DET_PAT);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    init = 5'b00000; repeat_cnt = 4'd0; gap_len = 3'd0;
    cyc(); cyc();
    checks++;
    if ({dout, dout_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000", {dout, dout_valid, busy, done});
    end
    resetn = 1'b1;
    cyc();
    checks++;
    if ({dout, dout_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 0000", {dout, dout_valid, busy, done});
    end
  endtask

  task automatic test_single();
    logic [4:0] pat;
    pat = 5'b10110;
    init = pat; repeat_cnt = 4'd0; gap_len = 3'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== pat[4-i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL single_bit%0d got v=%b d=%b b=%b dn=%b want v=1 d=%b b=1 dn=0",
                 i, dout_valid, dout, busy, done, pat[4-i]);
      end
      cyc();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0 || det_seen !== 1'b1) begin
      errors++;
      $display("FAIL single_done got dn=%b b=%b v=%b seen=%b want 1 0 0 1",
               done, busy, dout_valid, det_seen);
    end
    cyc();
    checks++;
    if (done !== 1'b0 || dout !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse got dn=%b d=%b want 0 0", done, dout);
    end
  endtask

  task automatic test_repeat_gap();
    logic [4:0] pat;
    logic       ev, ed;
    int         seen_cnt, done_cnt, ph;
    pat = 5'b10110; seen_cnt = 0; done_cnt = 0;
    init = pat; repeat_cnt = 4'd2; gap_len = 3'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int p = 0; p < 21; p++) begin
      ph = p % 8;
      ev = (ph < 5);
      ed = ev ? pat[4-ph] : 1'b0;
      seen_cnt += det_seen;
      done_cnt += done;
      checks++;
      if (dout_valid !== ev || dout !== ed || busy !== 1'b1) begin
        errors++;
        $display("FAIL gap_cycle%0d got v=%b d=%b b=%b want v=%b d=%b b=1",
                 p, dout_valid, dout, busy, ev, ed);
      end
      cyc();
    end
    seen_cnt += det_seen;
    done_cnt += done;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_end got dn=%b b=%b want 1 0", done, busy);
    end
    checks++;
    if (seen_cnt != 3 || done_cnt != 1) begin
      errors++;
      $display("FAIL gap_counts got seen=%0d done=%0d want 3 1", seen_cnt, done_cnt);
    end
    cyc();
  endtask

  task automatic test_no_gap_capture();
    logic [4:0] pat;
    pat = 5'b11001;
    init = pat; repeat_cnt = 4'd1; gap_len = 3'd0; start = 1'b1;
    cyc();
    start = 1'b0; init = 5'b00110; repeat_cnt = 4'd7; gap_len = 3'd5;
    for (int p = 0; p < 10; p++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== pat[4-(p%5)]) begin
        errors++;
        $display("FAIL nogap_bit%0d got v=%b d=%b want v=1 d=%b",
                 p, dout_valid, dout, pat[4-(p%5)]);
      end
      cyc();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nogap_done got dn=%b b=%b want 1 0", done, busy);
    end
    cyc();
  endtask

  task automatic test_abort();
    int done_cnt;
    done_cnt = 0;
    init = 5'b10110; repeat_cnt = 4'd2; gap_len = 3'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int p = 0; p < 9; p++) begin
      done_cnt += done;
      cyc();
    end
    checks++;
    if (dout_valid !== 1'b1 || dout !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got v=%b d=%b want 1 1", dout_valid, dout);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_next got v=%b b=%b dn=%b want 0 0 0", dout_valid, busy, done);
    end
    for (int p = 0; p < 4; p++) begin
      done_cnt += done;
      cyc();
    end
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone got done_cnt=%0d b=%b want 0 0", done_cnt, busy);
    end
    init = 5'b11100; repeat_cnt = 4'd0; gap_len = 3'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart got v=%b d=%b b=%b want 1 1 1", dout_valid, dout, busy);
    end
    for (int p = 0; p < 5; p++) cyc();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart_done got %b want 1", done);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [4:0] pat;
    logic       ev, edn;
    pat = 5'b10110;
    init = pat; repeat_cnt = 4'd0; gap_len = 3'd0; start = 1'b1;
    cyc();
    for (int p = 0; p < 12; p++) begin
      ev  = (p % 6) != 5;
      edn = (p % 6) == 5;
      checks++;
      if (dout_valid !== ev || done !== edn || busy !== ev ||
          (ev && dout !== pat[4-(p%6)])) begin
        errors++;
        $display("FAIL b2b_cycle%0d got v=%b dn=%b b=%b d=%b want v=%b dn=%b",
                 p, dout_valid, done, busy, dout, ev, edn);
      end
      if (p == 11) start = 1'b0;
      cyc();
    end
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop got b=%b v=%b want 0 0", busy, dout_valid);
    end
    start = 1'b1; abort = 1'b1;
    cyc(); cyc();
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort_blocks got b=%b v=%b want 0 0", busy, dout_valid);
    end
    start = 1'b0; abort = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_gap();
    init = 5'b10110; repeat_cnt = 4'd1; gap_len = 3'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int p = 0; p < 6; p++) cyc();
    checks++;
    if (busy !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_before_reset got b=%b v=%b want 1 0", busy, dout_valid);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({dout, dout_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got %b want 0000", {dout, dout_valid, busy, done});
    end
    cyc();
    resetn = 1'b1;
    cyc();
    checks++;
    if ({dout, dout_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle got %b want 0000", {dout, dout_valid, busy, done});
    end
    init = 5'b01101; repeat_cnt = 4'd0; gap_len = 3'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_start got v=%b d=%b b=%b want 1 0 1", dout_valid, dout, busy);
    end
    cyc();
    checks++;
    if (dout !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_bit1 got %b want 1", dout);
    end
    for (int p = 0; p < 4; p++) cyc();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_done got %b want 1", done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_repeat_gap();
    test_no_gap_capture();
    test_abort();
    test_back_to_back();
    test_reset_mid_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
